// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, counter type and the delayed control bundle.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // hs/vs are internal active-high "inside sync" flags; polarity is applied at the pins
    typedef struct packed {
        logic blank;
        logic hs;
        logic vs;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{blank: 1'b0, hs: 1'b0, vs: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that delays a control bundle by DEPTH clocks.
// Latency: DEPTH cycles (DEPTH=0 is a plain wire).
// Backpressure: none; shifts every cycle.
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             VGA_Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = VGA_Clk ^ Reset;
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            // shift one stage per clock; reset loads the idle pattern everywhere
            always_ff @(posedge VGA_Clk or posedge Reset) begin
                if (Reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// Raster counters, undelayed decodes for the compositor, and the aligned VGA pin stage.
// Latency: DrawX/DrawY to VGA_* is PIPE_DELAY+1 cycles; decodes align with DrawX/DrawY.
// Backpressure: none; free-running at one pixel per VGA_Clk.
module vga_timing_out
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter int   PIPE_DELAY  = 2,      // compositor latency, 0..4
    parameter logic SYNC_ACTIVE = 1'b0    // pin level while HS/VS asserted
) (
    input  logic       VGA_Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       frame_clk,
    output logic       frame_start,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FP + V_SYNC);

    cnt_t  hc, vc;
    cnt_t  hc_nxt, vc_nxt;
    logic  running;     // low for the first edge after reset so the raster opens at (0,0)
    ctrl_t ctrl_raw;
    ctrl_t ctrl_dly;

    // next raster position; held at the origin on the first edge out of reset
    always_comb begin
        hc_nxt = '0;
        vc_nxt = '0;
        if (running) begin
            if (hc == H_LAST) begin
                hc_nxt = '0;
                vc_nxt = (vc == V_LAST) ? '0 : vc + cnt_t'(1);
            end else begin
                hc_nxt = hc + cnt_t'(1);
                vc_nxt = vc;
            end
        end
    end

    // counters and their decodes update together so the decodes describe DrawX/DrawY
    always_ff @(posedge VGA_Clk or posedge Reset) begin
        if (Reset) begin
            running     <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            ctrl_raw    <= CTRL_IDLE;
            frame_start <= 1'b0;
        end else begin
            running        <= 1'b1;
            hc             <= hc_nxt;
            vc             <= vc_nxt;
            ctrl_raw.blank <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
            ctrl_raw.hs    <= (hc_nxt >= HS_START) && (hc_nxt < HS_END);
            ctrl_raw.vs    <= (vc_nxt >= VS_START) && (vc_nxt < VS_END);
            frame_start    <= (hc_nxt == '0) && (vc_nxt == '0);
        end
    end

    assign DrawX     = hc;
    assign DrawY     = vc;
    assign blank     = ctrl_raw.blank;
    assign frame_clk = ctrl_raw.vs;

    // match the compositor's latency so sync/blank line up with its RGB
    sync_delay_line #(
        .WIDTH   ($bits(ctrl_t)),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_dly (
        .VGA_Clk (VGA_Clk),
        .Reset   (Reset),
        .d       (ctrl_raw),
        .q       (ctrl_dly)
    );

    // pin register: black outside the visible area, sync polarity applied here
    always_ff @(posedge VGA_Clk or posedge Reset) begin
        if (Reset) begin
            VGA_R  <= 8'h00;
            VGA_G  <= 8'h00;
            VGA_B  <= 8'h00;
            VGA_HS <= ~SYNC_ACTIVE;
            VGA_VS <= ~SYNC_ACTIVE;
        end else begin
            VGA_R  <= ctrl_dly.blank ? Red_in   : 8'h00;
            VGA_G  <= ctrl_dly.blank ? Green_in : 8'h00;
            VGA_B  <= ctrl_dly.blank ? Blue_in  : 8'h00;
            VGA_HS <= ctrl_dly.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            VGA_VS <= ctrl_dly.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Directed bench: full 800-pixel lines with a shortened 10-line frame for vertical timing.
// Latency: checks VGA_* at PIPE_DELAY+1 cycles after DrawX/DrawY.
// Backpressure: n/a.
module tb_vga_timing_out;

    localparam int PD    = 2;
    localparam int LAT   = PD + 1;
    localparam int HT    = 800;
    localparam int VV    = 4;
    localparam int VT    = 10;            // 4 visible + 2 fp + 2 sync + 2 bp
    localparam int FRAME = HT * VT;       // 8000 cycles
    localparam int T_WIN = 2 * FRAME + 10;
    localparam int T_RST = 2 * FRAME + 7 * HT + 700;   // DrawX=700, DrawY=7

    logic       VGA_Clk  = 1'b0;
    logic       Reset    = 1'b1;
    logic [7:0] Red_in   = 8'h00;
    logic [7:0] Green_in = 8'h3C;
    logic [7:0] Blue_in  = 8'h00;
    logic [9:0] DrawX, DrawY;
    logic       blank, frame_clk, frame_start, VGA_HS, VGA_VS;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing_out #(
        .V_VISIBLE   (VV),
        .V_FP        (2),
        .V_SYNC      (2),
        .V_BP        (2),
        .PIPE_DELAY  (PD),
        .SYNC_ACTIVE (1'b0)
    ) dut (
        .VGA_Clk     (VGA_Clk),
        .Reset       (Reset),
        .Red_in      (Red_in),
        .Green_in    (Green_in),
        .Blue_in     (Blue_in),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .frame_clk   (frame_clk),
        .frame_start (frame_start),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B)
    );

    always #20 VGA_Clk = ~VGA_Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // compositor colour for raster pixel index p: x[7:0] in frame 0, full red afterwards
    function automatic logic [7:0] red_of(input int p);
        int px;
        px = p % HT;
        return (p < FRAME) ? 8'(px) : 8'hFF;
    endfunction

    initial begin
        int x, y, p, px, py, q;
        logic vis, e_hs, e_vs;
        logic [7:0] e_r, e_g, e_b;
        int err_draw = 0, err_dec = 0, err_out = 0, err_post = 0;
        int fs_cnt = 0, last_fs = -1, hs_low = 0, first_hs = -1;
        int vs_low = 0, first_vs = -1, fclk_hi = 0, r_ff = 0;

        // reset held: pins idle, counters and decodes cleared
        repeat (3) @(negedge VGA_Clk);
        check("rst_hs", VGA_HS, 1);
        check("rst_vs", VGA_VS, 1);
        check("rst_r", VGA_R, 0);
        check("rst_g", VGA_G, 0);
        check("rst_b", VGA_B, 0);
        check("rst_drawx", DrawX, 0);
        check("rst_drawy", DrawY, 0);
        check("rst_blank", blank, 0);
        check("rst_fclk", frame_clk, 0);
        check("rst_fstart", frame_start, 0);
        Reset = 1'b0;

        for (int t = 0; t <= T_RST; t++) begin
            @(negedge VGA_Clk);
            x = t % HT;
            y = (t / HT) % VT;
            if (DrawX !== 10'(x) || DrawY !== 10'(y)) err_draw++;
            if (blank !== (x < 640 && y < VV) || frame_clk !== (y >= 6 && y < 8) ||
                frame_start !== (x == 0 && y == 0)) err_dec++;

            p = t - LAT;
            if (p < 0) begin
                e_hs = 1'b1; e_vs = 1'b1; e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
            end else begin
                px   = p % HT;
                py   = (p / HT) % VT;
                vis  = (px < 640) && (py < VV);
                e_hs = !(px >= 656 && px < 752);
                e_vs = !(py >= 6 && py < 8);
                e_r  = vis ? red_of(p) : 8'h00;
                e_g  = vis ? 8'h3C : 8'h00;
                e_b  = vis ? ~8'(px) : 8'h00;
            end
            if (VGA_HS !== e_hs || VGA_VS !== e_vs || VGA_R !== e_r ||
                VGA_G !== e_g || VGA_B !== e_b) err_out++;

            if (t == 0) begin
                check("first_drawx", DrawX, 0);
                check("first_drawy", DrawY, 0);
                check("first_blank", blank, 1);
                check("first_fstart", frame_start, 1);
            end
            if (t == HT - 1) begin
                check("eol_drawx", DrawX, 799);
                check("eol_drawy", DrawY, 0);
            end
            if (t == HT) begin
                check("wrap_drawx", DrawX, 0);
                check("wrap_drawy", DrawY, 1);
            end

            if (t < T_WIN) begin
                if (frame_start) begin fs_cnt++; last_fs = t; end
                if (!VGA_HS) begin hs_low++; if (first_hs < 0) first_hs = t; end
                if (!VGA_VS) begin vs_low++; if (first_vs < 0) first_vs = t; end
                if (frame_clk) fclk_hi++;
                if (p >= FRAME && p < 2 * FRAME && VGA_R == 8'hFF) r_ff++;
            end

            // compositor model: colour of the pixel shown PD cycles earlier
            q = t - PD;
            Red_in  = (q >= 0) ? red_of(q) : 8'h00;
            Blue_in = (q >= 0) ? ~8'(q % HT) : 8'h00;
        end

        check("draw_seq_errs", err_draw, 0);
        check("decode_errs", err_dec, 0);
        check("pin_errs", err_out, 0);
        check("fstart_count", fs_cnt, 3);
        check("fstart_last", last_fs, 2 * FRAME);
        check("hs_first_low", first_hs, 656 + LAT);
        check("hs_low_total", hs_low, 20 * 96);
        check("vs_first_low", first_vs, 6 * HT + LAT);
        check("vs_low_total", vs_low, 2 * 1600);
        check("fclk_hi_total", fclk_hi, 2 * 1600);
        check("red_ff_frame1", r_ff, VV * 640);

        // mid-sync reset: pins must go idle immediately
        check("pre_rst_hs", VGA_HS, 0);
        check("pre_rst_vs", VGA_VS, 0);
        Reset = 1'b1;
        Red_in = 8'h00;
        Blue_in = 8'h00;
        #1;
        check("arst_hs", VGA_HS, 1);
        check("arst_vs", VGA_VS, 1);
        check("arst_drawx", DrawX, 0);
        check("arst_drawy", DrawY, 0);
        check("arst_fclk", frame_clk, 0);
        repeat (3) @(negedge VGA_Clk);
        Reset = 1'b0;

        for (int t2 = 0; t2 < 6; t2++) begin
            @(negedge VGA_Clk);
            if (VGA_HS !== 1'b1 || VGA_VS !== 1'b1 || VGA_R !== 8'h00) err_post++;
            if (t2 == 0) begin
                check("restart_drawx", DrawX, 0);
                check("restart_drawy", DrawY, 0);
                check("restart_fstart", frame_start, 1);
            end
            if (t2 == 1) check("restart_step", DrawX, 1);
        end
        check("post_rst_sync", err_post, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
